// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed 7-segment driver for the recorder status.
// Digit 0 shows the 1-based clip number. Digit 1 shows the mode letter
// ('r' or 'P'), and that letter blinks while busy. All other digits are blank.
// Inputs are captured once per frame so that a digit never changes mid-scan.
module seg_scan_display #(
    parameter int NUM_DIGITS  = 8,
    parameter int CLIP_BITS   = 2,
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 2,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [CLIP_BITS-1:0]  clip_num,
    input  logic                  mode,
    input  logic                  busy,
    output logic [6:0]            cathode,
    output logic [NUM_DIGITS-1:0] anode
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_DIGITS - 1);
    localparam logic [BW-1:0] BLK_MAX   = BW'(BLINK_DIV - 1);

    localparam logic [6:0] BLANK   = 7'b1111111;
    localparam logic [6:0] GLYPH_R = 7'b1111010;
    localparam logic [6:0] GLYPH_P = 7'b0011000;

    typedef struct packed {
        logic [CLIP_BITS-1:0] clip;
        logic                 mode;
        logic                 busy;
    } shadow_t;

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [BW-1:0]         bcnt;
    logic                  phase;
    shadow_t               sh;
    logic [6:0]            clip_glyph;
    logic [6:0]            glyph;
    logic [6:0]            cathode_d;
    logic [NUM_DIGITS-1:0] anode_d;

    // Slot counter and digit index. Both restart from digit 0 while the display is disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (!enable) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Frame-start capture, so that mid-frame input changes wait for the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sh <= '0;
        else if (enable && cnt == '0 && idx == '0)
            sh <= '{clip: clip_num, mode: mode, busy: busy};
    end

    // Blink timer runs only while busy. Holding it at 0 otherwise means each busy period starts visible.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (!enable || !sh.busy) begin
            bcnt  <= '0;
            phase <= 1'b0;
        end else if (bcnt == BLK_MAX) begin
            bcnt  <= '0;
            phase <= ~phase;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end

    // Clip number glyph: shows clip_s + 1, as digits 1..8.
    always_comb begin
        clip_glyph = BLANK;
        case (3'(sh.clip))
            3'd0: clip_glyph = 7'b1001111;
            3'd1: clip_glyph = 7'b0010010;
            3'd2: clip_glyph = 7'b0000110;
            3'd3: clip_glyph = 7'b1001100;
            3'd4: clip_glyph = 7'b0100100;
            3'd5: clip_glyph = 7'b0100000;
            3'd6: clip_glyph = 7'b0001111;
            3'd7: clip_glyph = 7'b0000000;
            default: clip_glyph = BLANK;
        endcase
    end

    // Next output: dark during the guard window or when disabled, otherwise the current digit.
    always_comb begin
        glyph     = BLANK;
        anode_d   = '0;
        cathode_d = BLANK;
        if (idx == '0)
            glyph = clip_glyph;
        else if (idx == IW'(1))
            glyph = (sh.busy && phase) ? BLANK : (sh.mode ? GLYPH_P : GLYPH_R);
        if (enable && cnt >= CNT_GUARD) begin
            anode_d   = NUM_DIGITS'(1) << idx;
            cathode_d = glyph;
        end
    end

    // Registered pin drivers. The async reset blanks the display without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode   <= '0;
            cathode <= BLANK;
        end else begin
            anode   <= anode_d;
            cathode <= cathode_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display. The stimulus side drives the inputs
// and predicts each cycle's pins from a frame-position model. That model
// takes the slot and digit from an enabled-cycle count and the blink phase
// from a busy-cycle count. A separate monitor pops the predictions and
// compares them against the pins just after each clock edge.
module tb_seg_scan_display;

    localparam int ND = 4;
    localparam int CB = 3;
    localparam int RD = 8;
    localparam int G  = 2;
    localparam int BD = 64;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [CB-1:0] clip_num = '0;
    logic          mode = 1'b0;
    logic          busy = 1'b0;
    logic [6:0]    cathode;
    logic [ND-1:0] anode;

    seg_scan_display #(
        .NUM_DIGITS(ND), .CLIP_BITS(CB), .REFRESH_DIV(RD), .GUARD(G), .BLINK_DIV(BD)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .clip_num(clip_num),
        .mode(mode), .busy(busy), .cathode(cathode), .anode(anode)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ND-1:0] an;
        logic [6:0]    ca;
    } out_t;

    out_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference state: enabled cycles into the frame, busy cycles into the blink period, and the frame snapshot.
    int   run = 0;
    int   bt = 0;
    int   sh_clip = 0;
    bit   sh_mode = 1'b0;
    bit   sh_busy = 1'b0;
    logic [6:0] digits [0:7];

    // Predict the pins after the next edge, advance the model, then wait until just past that edge.
    task automatic step();
        out_t e;
        int   pos;
        int   d;
        e.an = '0;
        e.ca = 7'b1111111;
        if (reset) begin
            run = 0; bt = 0; sh_clip = 0; sh_mode = 0; sh_busy = 0;
        end else if (!enable) begin
            run = 0; bt = 0;
        end else begin
            pos = run % RD;
            d   = (run / RD) % ND;
            if (pos >= G) begin
                e.an = ND'(1) << d;
                if (d == 0)
                    e.ca = digits[sh_clip];
                else if (d == 1)
                    e.ca = (sh_busy && ((bt / BD) % 2 == 1)) ? 7'b1111111
                         : (sh_mode ? 7'b0011000 : 7'b1111010);
            end
            bt = sh_busy ? (bt + 1) % (2 * BD) : 0;
            if (run == 0) begin
                sh_clip = int'(clip_num); sh_mode = mode; sh_busy = busy;
            end
            run = (run + 1) % (RD * ND);
        end
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: compare the registered pins against the oldest prediction.
    out_t got, exp_o;
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_o = q.pop_front();
            got   = '{an: anode, ca: cathode};
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL pins t=%0t anode=%b cathode=%b expected anode=%b cathode=%b",
                         $time, anode, cathode, exp_o.an, exp_o.ca);
            end
        end
    end

    initial begin
        digits[0] = 7'b1001111; digits[1] = 7'b0010010; digits[2] = 7'b0000110;
        digits[3] = 7'b1001100; digits[4] = 7'b0100100; digits[5] = 7'b0100000;
        digits[6] = 7'b0001111; digits[7] = 7'b0000000;

        #2;
        repeat (3) step();
        reset = 1'b0;

        // Basic frame: clip 2, record mode, idle.
        enable = 1'b1; clip_num = 3'd1; mode = 1'b0; busy = 1'b0;
        repeat (64) step();

        // Clip change while digit 1 is scanning should wait for the next frame.
        for (int k = 0; k < 64 && run != RD + 3; k++) step();
        clip_num = 3'd2;
        repeat (48) step();

        // Play mode with busy blink, then busy released.
        mode = 1'b1; busy = 1'b1;
        repeat (300) step();
        busy = 1'b0;
        repeat (64) step();

        // Disable during the digit 1 slot, then re-enable.
        for (int k = 0; k < 64 && run != RD + 4; k++) step();
        enable = 1'b0;
        repeat (3) step();
        enable = 1'b1;
        repeat (40) step();

        // Clip range extremes.
        clip_num = 3'd7;
        repeat (40) step();
        clip_num = 3'd0;
        repeat (40) step();

        // Async reset in the middle of a lit slot.
        for (int k = 0; k < 64 && run != 5; k++) step();
        checks++;
        if (anode == '0) begin
            errors++;
            $display("FAIL prelit anode=%b expected nonzero", anode);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (anode !== '0 || cathode !== 7'b1111111) begin
            errors++;
            $display("FAIL async_reset anode=%b cathode=%b expected 0000/1111111", anode, cathode);
        end
        repeat (2) step();
        reset = 1'b0;
        repeat (40) step();

        // Random input traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) < 5) clip_num = CB'($urandom);
            if ($urandom_range(99) < 5) mode = 1'($urandom);
            if ($urandom_range(199) < 2) busy = ~busy;
            if ($urandom_range(199) < 3) enable = ~enable;
            else if (!enable && $urandom_range(9) < 3) enable = 1'b1;
            step();
        end

        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
